// File: rtl/line_merge_buffer_pkg.sv
// Shared sizes, FSM states and helpers for the line merge buffer.
// Imported by the interface, the top and the testbench.
package line_merge_buffer_pkg;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 32;
  localparam int LADDR_W = 25;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // True when exactly one bit of the mask is set.
  function automatic logic one_hot(
    input logic [WORDS-1:0] m
  );
    logic [WORDS-1:0] lsb;
    lsb = {{(WORDS-1){1'b0}}, 1'b1};
    return (m != '0) && ((m & (m - lsb)) == '0);
  endfunction

endpackage

// File: rtl/line_merge_buffer_if.sv
// Store-side and drain-side handshake bundle of the merge buffer.
// slave: the buffer itself; master: the store/memory side driving it.
interface line_merge_buffer_if;
  import line_merge_buffer_pkg::*;

  logic               st_valid;
  logic               st_ready;
  logic [LADDR_W-1:0] st_laddr;
  logic [WORDS-1:0]   st_wsel;
  logic [WORD_W-1:0]  st_data;
  logic               flush;

  logic               mem_valid;
  logic               mem_ready;
  logic [LADDR_W-1:0] mem_laddr;
  logic [IDX_W-1:0]   mem_idx;
  logic [WORD_W-1:0]  mem_data;
  logic               mem_last;

  logic               busy;
  logic [WORDS-1:0]   dirty_mask;

  modport slave (
    input  st_valid, st_laddr, st_wsel,
    input  st_data, flush, mem_ready,
    output st_ready, mem_valid, mem_laddr,
    output mem_idx, mem_data, mem_last,
    output busy, dirty_mask
  );

  modport master (
    output st_valid, st_laddr, st_wsel,
    output st_data, flush, mem_ready,
    input  st_ready, mem_valid, mem_laddr,
    input  mem_idx, mem_data, mem_last,
    input  busy, dirty_mask
  );

endinterface

// File: rtl/line_merge_buffer_prio_enc32to5.sv
// Lowest-set-bit priority encoder: 32-bit mask in, 5-bit index out.
// Ports: i_mask (mask), o_idx (lowest set bit), o_none (mask empty).
module prio_enc32to5 (
  input  logic [31:0] i_mask,
  output logic [4:0]  o_idx,
  output logic        o_none
);

  // Scanning downward leaves the lowest set bit as the winner.
  always_comb begin
    o_idx  = '0;
    o_none = (i_mask == '0);
    for (int i = 31; i >= 0; i--) begin
      if (i_mask[i]) o_idx = 5'(i);
    end
  end

endmodule

// File: rtl/line_merge_buffer.sv
// Merges CPU stores into one held line, drains dirty words in index order.
// Ports: clk, reset (async, active-high), bus (slave side of the bundle).
module line_merge_buffer
  import line_merge_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  line_merge_buffer_if.slave  bus
);

  state_e             r_state;
  state_e             w_next;
  logic [LADDR_W-1:0] r_laddr;
  logic [WORD_W-1:0]  r_words [WORDS];
  logic [WORDS-1:0]   r_dirty;
  logic [WORDS-1:0]   w_dirty_nxt;
  logic [WORDS-1:0]   w_we;
  logic [WORDS-1:0]   w_clr;
  logic [IDX_W-1:0]   w_idx;
  logic               w_none;
  logic               w_match;
  logic               w_st_ready;
  logic               w_st_fire;
  logic               w_drain;
  logic               w_beat;
  logic               w_last;

  prio_enc32to5 u_prio (
    .i_mask (r_dirty),
    .o_idx  (w_idx),
    .o_none (w_none)
  );

  assign w_match    = (bus.st_laddr == r_laddr);
  assign w_drain    = (r_state == S_DRAIN);
  assign w_st_ready = (r_state == S_IDLE) |
                      ((r_state == S_MERGE) & w_match);
  assign w_st_fire  = bus.st_valid & w_st_ready;
  // Word write enables: decoder select gated by acceptance.
  assign w_we       = w_st_fire ? bus.st_wsel : '0;
  assign w_beat     = w_drain & ~w_none & bus.mem_ready;
  assign w_last     = one_hot(r_dirty);
  assign w_clr      = {{(WORDS-1){1'b0}}, 1'b1} << w_idx;

  always_comb begin
    w_next      = r_state;
    w_dirty_nxt = r_dirty;
    unique case (r_state)
      S_IDLE: begin
        if (w_we != '0) begin
          w_next      = S_MERGE;
          w_dirty_nxt = w_we;
        end
      end
      S_MERGE: begin
        // A same-cycle matching store is merged before draining.
        w_dirty_nxt = r_dirty | w_we;
        if (bus.flush || (bus.st_valid && !w_match))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_beat) begin
          w_dirty_nxt = r_dirty & ~w_clr;
          if (w_last) w_next = S_IDLE;
        end
      end
      default: begin
        w_next      = S_IDLE;
        w_dirty_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      r_dirty <= w_dirty_nxt;
    end
  end

  // Line payload and address carry no reset; dirty bits qualify them.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && (w_we != '0))
      r_laddr <= bus.st_laddr;
    for (int i = 0; i < WORDS; i++) begin
      if (w_we[i]) r_words[i] <= bus.st_data;
    end
  end

  assign bus.st_ready   = w_st_ready;
  assign bus.mem_valid  = w_drain & ~w_none;
  assign bus.mem_laddr  = r_laddr;
  assign bus.mem_idx    = w_idx;
  assign bus.mem_data   = r_words[w_idx];
  assign bus.mem_last   = w_drain & w_last;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.dirty_mask = r_dirty;

endmodule
